// File: rtl/qkv_proj_seq.sv
// Sequencer for NUM_CH projection engines: owns the host LOAD -> RUN -> READ flow,
// steers host writes/reads onto the per-channel SRAMs and tracks run completion.
`timescale 1ns/1ps
module qkv_proj_seq #(
    parameter int NUM_CH  = 3,
    parameter int DW      = 128,
    parameter int IN_AW   = 5,
    parameter int W_AW    = 10,
    parameter int OUT_AW  = 7,
    parameter int TIMEOUT = 4096,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req,
    input  logic                 load_done,
    input  logic                 start,
    input  logic [NUM_CH-1:0]    ch_mask,
    input  logic                 read_req,
    input  logic                 read_done,
    input  logic                 wr_valid,
    input  logic                 wr_bank,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [W_AW-1:0]      wr_addr,
    input  logic [DW-1:0]        wr_data,
    input  logic                 rd_valid,
    input  logic [CH_W-1:0]      rd_ch,
    input  logic [OUT_AW-1:0]    rd_addr,
    input  logic [NUM_CH*DW-1:0] out_q,
    input  logic [NUM_CH-1:0]    eng_finished,
    output logic                 init_sel,
    output logic                 fin_sel,
    output logic [NUM_CH-1:0]    h_in_web,
    output logic [NUM_CH-1:0]    h_w_web,
    output logic [W_AW-1:0]      h_addr,
    output logic [DW-1:0]        h_din,
    output logic [OUT_AW-1:0]    h_out_addr,
    output logic [NUM_CH-1:0]    eng_en,
    output logic [DW-1:0]        rdata,
    output logic                 rdata_valid,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout
);

    localparam int WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_RUN,
        ST_READ
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [NUM_CH-1:0]   seen_q, seen_d;
    logic [NUM_CH-1:0]   in_web_q, in_web_d;
    logic [NUM_CH-1:0]   w_web_q, w_web_d;
    logic [W_AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]       din_q, din_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic [WD_W-1:0]     wd_q, wd_d;
    logic                rvalid_q, rvalid_d;
    logic [CH_W-1:0]     rch_q, rch_d;

    logic                wr_ok;
    logic [NUM_CH-1:0]   wr_sel;
    logic [NUM_CH-1:0]   fin_now;
    logic                run_complete;
    logic                wd_hit;
    logic [DW-1:0]       rdata_mux;

    // Writes to a channel index that does not exist are silently dropped.
    assign wr_ok = (state_q == ST_LOAD) && wr_valid &&
                   ({1'b0, wr_ch} < (CH_W+1)'(NUM_CH));

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = wr_ok && (wr_ch == CH_W'(gi));
        end
    endgenerate

    assign fin_now      = seen_q | (eng_finished & mask_q);
    assign run_complete = (fin_now == mask_q);
    assign wd_hit       = (TIMEOUT > 0) && (wd_q == WD_W'(WD_LIM));

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        seen_d    = seen_q;
        addr_d    = addr_q;
        din_d     = din_q;
        done_d    = 1'b0;
        timeout_d = timeout_q;
        wd_d      = wd_q;
        rvalid_d  = 1'b0;
        rch_d     = rch_q;
        in_web_d  = ~(wr_sel & {NUM_CH{~wr_bank}});
        w_web_d   = ~(wr_sel & {NUM_CH{wr_bank}});

        case (state_q)
            ST_IDLE: begin
                if (load_req) begin
                    state_d = ST_LOAD;
                end else if (start) begin
                    mask_d    = ch_mask;
                    timeout_d = 1'b0;
                    wd_d      = '0;
                    seen_d    = '0;
                    if (ch_mask == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else if (read_req) begin
                    state_d = ST_READ;
                end
            end
            ST_LOAD: begin
                if (wr_ok) begin
                    addr_d = wr_addr;
                    din_d  = wr_data;
                end
                if (load_done) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_d = ST_IDLE;
            end
            ST_RUN: begin
                seen_d = fin_now;
                wd_d   = wd_q + WD_W'(1);
                // Completion is checked first so it wins over a same-cycle watchdog expiry.
                if (run_complete) begin
                    done_d  = 1'b1;
                    seen_d  = '0;
                    wd_d    = '0;
                    state_d = ST_IDLE;
                end else if (wd_hit) begin
                    timeout_d = 1'b1;
                    seen_d    = '0;
                    wd_d      = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_READ: begin
                if (rd_valid) begin
                    rvalid_d = 1'b1;
                    rch_d    = rd_ch;
                end
                if (read_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            seen_q    <= '0;
            in_web_q  <= '1;
            w_web_q   <= '1;
            addr_q    <= '0;
            din_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            wd_q      <= '0;
            rvalid_q  <= 1'b0;
            rch_q     <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            seen_q    <= seen_d;
            in_web_q  <= in_web_d;
            w_web_q   <= w_web_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            wd_q      <= wd_d;
            rvalid_q  <= rvalid_d;
            rch_q     <= rch_d;
        end
    end

    // The output SRAMs return data one cycle after the address, so select with the registered channel.
    always_comb begin
        rdata_mux = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rch_q == CH_W'(i)) begin
                rdata_mux = out_q[i*DW +: DW];
            end
        end
    end

    assign init_sel    = (state_q == ST_LOAD) || (state_q == ST_FLUSH);
    assign fin_sel     = (state_q == ST_READ);
    assign h_out_addr  = fin_sel ? rd_addr : '0;
    assign h_in_web    = in_web_q;
    assign h_w_web     = w_web_q;
    assign h_addr      = addr_q;
    assign h_din       = din_q;
    assign eng_en      = (state_q == ST_RUN) ? (mask_q & ~seen_q) : '0;
    assign rdata       = rvalid_q ? rdata_mux : '0;
    assign rdata_valid = rvalid_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign timeout     = timeout_q;

endmodule
